// File: rtl/div32_pkg.sv
// Shared types and constants for the div32 sequential restoring divider.
package div32_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;
  localparam logic [DIV_W-1:0] DZ_QUOTIENT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

endpackage

// File: rtl/div32_if.sv
// Request/response bundle between a div32 client (master) and the divider (slave).
interface div32_if;
  import div32_pkg::*;

  logic                 start;
  logic [DIV_W-1:0]     a;
  logic [DIV_W-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic [2*DIV_W-1:0]   result;

  modport master (
    output start, a, b,
    input  busy, done, div_by_zero, result
  );

  modport slave (
    input  start, a, b,
    output busy, done, div_by_zero, result
  );

endinterface

// File: rtl/div32_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div32_step
  import div32_pkg::*;
(
  input  logic [DIV_W:0]   rem,
  input  logic             dvd_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   rem_next,
  output logic             q_bit
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W:0]   diff;

  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted[DIV_W:0] - {1'b0, divisor};
    q_bit    = (shifted >= {2'b00, divisor});
    rem_next = q_bit ? diff : shifted[DIV_W:0];
  end

endmodule

// File: rtl/div32.sv
// Sequential 32-bit restoring divider, one quotient bit per clock, {rem, quo} result.
// Define DIV32_SIGNED_EN to treat a/b as two's complement (magnitude divide + sign fixup).
module div32
  import div32_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  div32_if.slave bus
);

  state_t               state_reg, state_next;
  logic                 busy_next;
  logic [DIV_W:0]       rem_reg;
  logic [DIV_W-1:0]     dvd_reg;
  logic [DIV_W-1:0]     dvs_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 dz_reg;
  logic                 done_reg;
  logic                 dz_out_reg;
  logic [2*DIV_W-1:0]   result_reg;

  logic [DIV_W:0]       step_rem;
  logic                 step_q;
  logic [DIV_W-1:0]     a_mag, b_mag, quo_fix, rem_fix;

  div32_step u_step (
    .rem      (rem_reg),
    .dvd_msb  (dvd_reg[DIV_W-1]),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

`ifdef DIV32_SIGNED_EN
  logic neg_q_reg, neg_r_reg;

  always_comb begin
    a_mag   = bus.a[DIV_W-1] ? -bus.a : bus.a;
    b_mag   = bus.b[DIV_W-1] ? -bus.b : bus.b;
    quo_fix = neg_q_reg ? -dvd_reg : dvd_reg;
    rem_fix = neg_r_reg ? -rem_reg[DIV_W-1:0] : rem_reg[DIV_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (state_reg == IDLE && bus.start) begin
      neg_q_reg <= bus.a[DIV_W-1] ^ bus.b[DIV_W-1];
      neg_r_reg <= bus.a[DIV_W-1];
    end
  end
`else
  always_comb begin
    a_mag   = bus.a;
    b_mag   = bus.b;
    quo_fix = dvd_reg;
    rem_fix = rem_reg[DIV_W-1:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // busy covers the accepting cycle itself, so a request is visibly taken at once
  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b1;
    case (state_reg)
      IDLE: begin
        busy_next = bus.start;
        if (bus.start) state_next = (bus.b == '0) ? FINISH : CALC;
      end
      CALC: begin
        if (cnt_reg == CNT_W'(DIV_W - 1)) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg    <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      dz_reg     <= 1'b0;
      done_reg   <= 1'b0;
      dz_out_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cnt_reg <= '0;
            rem_reg <= '0;
            if (bus.b == '0) begin
              // raw a is kept so the remainder field reports it unmodified
              dvd_reg <= bus.a;
              dz_reg  <= 1'b1;
            end else begin
              dvd_reg <= a_mag;
              dvs_reg <= b_mag;
              dz_reg  <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_reg <= step_rem;
          dvd_reg <= {dvd_reg[DIV_W-2:0], step_q};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FINISH: begin
          result_reg <= dz_reg ? {dvd_reg, DZ_QUOTIENT} : {rem_fix, quo_fix};
          dz_out_reg <= dz_reg;
          done_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_next;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dz_out_reg;
  assign bus.result      = result_reg;

endmodule

// File: tb/tb_div32.sv
// Directed plus randomized bench for div32 against a plain-arithmetic reference model.
module tb_div32;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  div32_if bus ();

  div32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, remainder, quotient}
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV32_SIGNED_EN
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, r, q};
`else
    if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
    return {1'b0, a % b, a / b};
`endif
  endfunction

  // Issue one request and follow it to done; glitch_at injects an extra start mid-flight.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [64:0] exp, input int glitch_at, input bit chained);
    int lat, bcnt, exp_lat;
    lat  = -1;
    bcnt = 0;
    exp_lat = exp[64] ? 1 : 33;
    if (!chained) @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    #1;
    if (bus.busy) bcnt++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) bcnt++;
      if (i == glitch_at) begin
        bus.start = 1'b1;
        bus.a = $urandom;
        bus.b = $urandom;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_lat + 1));
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " result"}, bus.result, exp[63:0]);
    chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp[64]));
    $display("op %s a=%h b=%h result=%h dz=%b latency=%0d", tag, a, b, bus.result,
             bus.div_by_zero, lat);
  endtask

  initial begin
    int extra_done;
    logic [31:0] ra, rb;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset dz", 64'(bus.div_by_zero), 64'd0);
    chk("reset result", bus.result, 64'd0);
    reset = 1'b0;

    run_op("100/7", 32'd100, 32'd7, {1'b0, 64'h00000002_0000000E}, -1, 1'b0);
    @(negedge clk);
    chk("done one-cycle pulse", 64'(bus.done), 64'd0);
    chk("result holds", bus.result, 64'h00000002_0000000E);
    run_op("ffffffff/1", 32'hFFFFFFFF, 32'd1, {1'b0, 64'h00000000_FFFFFFFF}, -1, 1'b0);
    run_op("x/x", 32'h12345678, 32'h12345678, {1'b0, 64'h00000000_00000001}, -1, 1'b0);
    run_op("5/0", 32'd5, 32'd0, {1'b1, 64'h00000005_FFFFFFFF}, -1, 1'b0);
    @(negedge clk);
    chk("dz holds", 64'(bus.div_by_zero), 64'd1);
`ifdef DIV32_SIGNED_EN
    run_op("-7/2", -32'sd7, 32'd2, {1'b0, 64'hFFFFFFFF_FFFFFFFD}, -1, 1'b0);
    run_op("7/-2", 32'd7, -32'sd2, {1'b0, 64'h00000001_FFFFFFFD}, -1, 1'b0);
    run_op("min/-1", 32'h80000000, 32'hFFFFFFFF, {1'b0, 64'h00000000_80000000}, -1, 1'b0);
`else
    run_op("8000_0000/ffff_ffff", 32'h80000000, 32'hFFFFFFFF,
           {1'b0, 64'h80000000_00000000}, -1, 1'b0);
    run_op("big/small", 32'hFFFFFFFE, 32'd3, {1'b0, 64'h00000002_55555554}, -1, 1'b0);
`endif

    run_op("ignored start", 32'hDEADBEEF, 32'h00001234, model(32'hDEADBEEF, 32'h00001234),
           10, 1'b0);
    extra_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("no second done", 64'(extra_done), 64'd0);

    ra = $urandom;
    rb = $urandom_range(1, 1000);
    run_op("b2b first", ra, rb, model(ra, rb), -1, 1'b0);
    ra = $urandom;
    rb = $urandom;
    run_op("b2b second", ra, rb, model(ra, rb), -1, 1'b1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort result", bus.result, 64'd0);
    chk("abort dz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk("abort no done", 64'(extra_done), 64'd0);
    run_op("after abort", 32'd1000, 32'd3, {1'b0, 64'h00000001_0000014D}, -1, 1'b0);

    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 3);
        1: rb = $urandom_range(1, 65535);
        2: rb = $urandom;
        default: rb = ra >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", k), ra, rb, model(ra, rb), -1, (k % 4) == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div32.md
# div32

Sequential 32-bit restoring divider, the inverse companion of the ALU's sequential multiplier. It accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, and returns a 64-bit `{remainder, quotient}` word. The 64-bit result has the same width as the ALU's multiplier output, so it feeds the ALU result mux directly.

## Interface
Parameters:
- None; widths are fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  dividend; captured on the accepted start.
- `b`  in  32  divisor; captured on the accepted start.
- `busy`  out  1  high from the accepted start through the FINISH cycle.
- `done`  out  1  one-cycle pulse when `result` updates.
- `div_by_zero`  out  1  valid with `done`; high when the captured `b` was 0. Holds until the next `done`.
- `result`  out  64  `{remainder[31:0], quotient[31:0]}`; holds until the next `done`.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE, `start`=1, `b`≠0:
  - Latch operand magnitudes.
  - Clear the 33-bit partial remainder.
  - Set `count`=0 and `busy`=1.
  - Go to CALC.
- IDLE, `start`=1, `b`=0: latch `a`, set the dz flag, go directly to FINISH (no CALC).
- CALC, each cycle:
  - Shift `{rem, dividend}` left by 1.
  - If `rem` ≥ divisor: subtract and shift in quotient bit 1; else shift in 0.
  - `count`++.
  - When `count`==31, this step is the last; go to FINISH.
- FINISH:
  - Apply sign fixup (see Configuration).
  - Register `result` and `div_by_zero`.
  - Pulse `done`, drop `busy`, return to IDLE.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = `a` (unmodified), `div_by_zero`=1.
- `start` while `busy`: ignored. No queueing, and the in-flight operation is unaffected.
- `start` in the same cycle that `done` is high: accepted, because the state is already IDLE.
- Operand changes after capture have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `result`=64'h0.
- Normal latency: start sampled at edge 0; CALC steps on edges 1–32; FINISH at edge 33. `done` is high in the cycle after edge 33, i.e. 33 cycles after acceptance.
- Divide-by-zero latency: `done` is high in the cycle after edge 1.
- Throughput: one operation per 34 cycles (normal) when back-to-back.
- Reset asserted mid-operation: immediately returns to IDLE with reset values. The previous `result` is lost, and no `done` is issued for the aborted operation.

## Configuration
- `DIV32_SIGNED_EN` defined: `a` and `b` are two's complement.
  - Magnitudes are divided.
  - Quotient negated when `a[31]`^`b[31]`; remainder takes the sign of `a`.
  - -2^31 / -1 yields quotient 32'h80000000, remainder 0, with no flag.
  - Divide-by-zero still returns all-ones / `a`.
- `DIV32_SIGNED_EN` undefined: unsigned-only. No magnitude or fixup logic; FINISH only registers.

## Structure
- Shared package `div32_pkg`: state enum (IDLE/CALC/FINISH), `DIV_W`=32, `CNT_W`=5, `DZ_QUOTIENT`=32'hFFFFFFFF.
- One sub-module, `div32_step`. It is combinational and computes one restoring step: (33-bit rem, dividend MSB, divisor) → (next rem, quotient bit). `div32` holds the FSM, the counter and the registers.

## Test plan
- Divide 100 by 7 (unsigned) → `result`=64'h00000002_0000000E, `done` exactly 33 cycles after the accepting edge, `div_by_zero`=0.
- Divide 32'hFFFFFFFF by 1 → 64'h00000000_FFFFFFFF; 32'h12345678 by 32'h12345678 → 64'h00000000_00000001.
- Divide 5 by 0 → 64'h00000005_FFFFFFFF, `div_by_zero`=1, `done` 1 cycle after acceptance, `busy` high for 2 cycles.
- `DIV32_SIGNED_EN`: -7 by 2 → 64'hFFFFFFFF_FFFFFFFD; 7 by -2 → 64'h00000001_FFFFFFFD; 32'h80000000 by 32'hFFFFFFFF → 64'h00000000_80000000.
- Pulse `start` with new operands at cycle 10 of an operation → ignored; the first result is correct and no second `done` occurs.
- Assert `reset` at cycle 15 of CALC → `busy`, `done` and `result` go to 0 immediately. A new start after release completes correctly.
